lcd_update_arbiter: RTL
=======================

Name: lcd_update_arbiter

Overview:
- Sits between two update sources and the LCD display driver: A (processor writeback) and B (user/inspection path).
- Each source presents an {opcode, addr, data} record.
- The block arbitrates round-robin and latches the winner's record onto the display driver inputs.
- It drives the driver's 2-bit command (OFF=0, UPD=1, IDLE=2) and tracks the done_display handshake. No update is lost, and none is issued while the driver is mid-refresh.

Parameters:
- TIMEOUT_CYCLES, 24'd10000000: max cycles waiting on any done_display edge before abort (sized above the worst-case full refresh, 41 instructions x 100k cycles ≈ 4.1M).
- TO_W, 24: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- power_on  in  1  1 = display enabled; 0 forces command OFF
- req_a  in  1  source A request; held until gnt_a
- opcode_a  in  4  source A opcode
- addr_a  in  4  source A register address
- data_a  in  16  source A value (bit15 sign, 14:0 magnitude)
- req_b  in  1  source B request
- opcode_b  in  4  source B opcode
- addr_b  in  4  source B register address
- data_b  in  16  source B value
- done_display  in  1  from display driver; 1 = refresh complete / idle
- gnt_a  out  1  one-cycle pulse: A's record captured
- gnt_b  out  1  one-cycle pulse: B's record captured
- command  out  2  to display driver
- opcode  out  4  to display driver, held stable during an update
- addr  out  4  to display driver, held stable during an update
- data_addr  out  16  to display driver, held stable during an update
- busy  out  1  1 in any state other than READY
- timeout_err  out  1  sticky; set on abort, cleared by reset or power_on falling

Behaviour:
- Reset (rst_n=0 at posedge clk): state=OFF, command=OFF, opcode/addr/data_addr=0, gnt_a=gnt_b=0, busy=1, timeout_err=0, last_winner=B (A wins the first tie).
- power_on=0, sampled in any state: next state OFF, command=OFF, counters cleared, timeout_err cleared. Any pending grant is not given.
- OFF: command=OFF. power_on=1 -> BOOT.
- BOOT: command=IDLE; driver initialises and refreshes. done_display=1 -> READY. Timeout -> READY with timeout_err=1.
- READY: command=IDLE, busy=0.
  - If exactly one req is high, that source wins.
  - If both are high, the source other than last_winner wins.
  - On winning: capture its fields into opcode/addr/data_addr, pulse its gnt for 1 cycle, update last_winner, go to ISSUE.
  - Requests are not sampled in any other state.
- ISSUE: command=UPD for exactly 1 cycle -> ACK_WAIT.
- ACK_WAIT: command=IDLE. Wait for done_display=0, which confirms the driver left its wait state -> BUSY. Timeout -> READY, timeout_err=1.
- BUSY: command=IDLE. Wait for done_display=1 -> READY. Timeout -> READY, timeout_err=1.
- Output fields are held constant from capture until the return to READY. Minimum request-to-request spacing is therefore one full refresh.
- Timeout counter: reset on every state entry. Abort fires when the count reaches TIMEOUT_CYCLES-1. Counts saturate and never wrap.
- Simultaneous power_on fall and grant decision: power_on wins; no gnt pulse.
- A request dropped before its grant is simply not served; there is no queuing beyond the request level.
- Latency: req sampled in READY -> gnt and fields valid next cycle -> command=UPD on the following cycle.

Optional Feature:
- Macro: LCD_ARB_DEDUP_EN.
- Defined: if the winning record equals the currently held {opcode, addr, data_addr} and the last update completed without timeout, the gnt pulse is still issued but the state stays READY. No UPD is sent and busy stays 0.
- Undefined: every grant issues a full update sequence.

Test Plan:
- Boot: reset, power_on=1, done_display held 0 for 50 cycles then 1 -> command IDLE throughout, busy falls to 0 one cycle after done_display=1, timeout_err=0.
- Single update: req_a with opcode=4'd1, addr=4'b0101, data=16'h8007 -> gnt_a pulse; command=UPD for 1 cycle; fields held until the model drops and then raises done_display; back in READY.
- Contention: req_a and req_b held high for 3 updates -> grants in order A, B, A; fields match the granted source each time.
- Timeout: TIMEOUT_CYCLES=100; after UPD, done_display stuck at 1 -> return to READY at cycle 100 of ACK_WAIT, timeout_err=1 (sticky) until power_on toggles.
- Power drop mid-BUSY: power_on=0 -> next cycle command=OFF, no gnt, timeout_err=0; on power_on=1 the BOOT sequence repeats.
- Dedup (LCD_ARB_DEDUP_EN defined): same A record sent twice -> second request produces gnt_a but no UPD cycle and busy stays 0; undefined -> second UPD issued.

Source files
------------

// File: rtl/lcd_update_arbiter.sv
// Round-robin arbiter between two LCD update sources; drives the display driver command/fields
// and tracks the done_display handshake. Optional macro LCD_ARB_DEDUP_EN suppresses repeat updates.
module lcd_update_arbiter #(
  parameter int unsigned      TO_W           = 24,
  parameter logic [TO_W-1:0]  TIMEOUT_CYCLES = 24'd10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power_on,
  input  logic        req_a,
  input  logic [3:0]  opcode_a,
  input  logic [3:0]  addr_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [3:0]  opcode_b,
  input  logic [3:0]  addr_b,
  input  logic [15:0] data_b,
  input  logic        done_display,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [1:0]  command,
  output logic [3:0]  opcode,
  output logic [3:0]  addr,
  output logic [15:0] data_addr,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_OFF, S_BOOT, S_READY, S_ISSUE, S_ACK_WAIT, S_BUSY
  } state_e;

  localparam logic [1:0]      CMD_OFF  = 2'd0;
  localparam logic [1:0]      CMD_UPD  = 2'd1;
  localparam logic [1:0]      CMD_IDLE = 2'd2;
  localparam logic [TO_W-1:0] TO_LAST  = TIMEOUT_CYCLES - 1'b1;

`ifdef LCD_ARB_DEDUP_EN
  localparam bit DEDUP_EN = 1'b1;
`else
  localparam bit DEDUP_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [3:0]      opcode_q, opcode_d, addr_q, addr_d;
  logic [15:0]     data_q, data_d;
  logic            gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic            err_q, err_d;
  logic            last_b_q, last_b_d;  // 1 = B won the most recent grant
  logic            ok_q, ok_d;          // last update finished cleanly

  logic            pick_a, pick_b, expired, same_rec;
  logic [3:0]      win_op, win_addr;
  logic [15:0]     win_data;

  assign pick_a   = req_a & (~req_b | last_b_q);
  assign pick_b   = req_b & ~pick_a;
  assign win_op   = pick_a ? opcode_a : opcode_b;
  assign win_addr = pick_a ? addr_a   : addr_b;
  assign win_data = pick_a ? data_a   : data_b;
  assign same_rec = ({win_op, win_addr, win_data} == {opcode_q, addr_q, data_q});
  assign expired  = (cnt_q >= TO_LAST);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    data_d   = data_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    err_d    = err_q;
    last_b_d = last_b_q;
    ok_d     = ok_q;

    // Command follows the registered state one cycle later.
    unique case (state_q)
      S_OFF:   cmd_d = CMD_OFF;
      S_ISSUE: cmd_d = CMD_UPD;
      default: cmd_d = CMD_IDLE;
    endcase

    unique case (state_q)
      S_OFF: if (power_on) state_d = S_BOOT;
      S_BOOT: begin
        if (done_display) state_d = S_READY;
        else if (expired) begin
          state_d = S_READY;
          err_d   = 1'b1;
        end
      end
      S_READY: begin
        if (pick_a || pick_b) begin
          gnt_a_d  = pick_a;
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          if (!(DEDUP_EN && ok_q && same_rec)) begin
            opcode_d = win_op;
            addr_d   = win_addr;
            data_d   = win_data;
            ok_d     = 1'b0;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_ACK_WAIT;
      S_ACK_WAIT: begin
        if (!done_display) state_d = S_BUSY;
        else if (expired) begin
          state_d = S_READY;
          err_d   = 1'b1;
        end
      end
      S_BUSY: begin
        if (done_display) begin
          state_d = S_READY;
          ok_d    = 1'b1;
        end else if (expired) begin
          state_d = S_READY;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Power loss overrides everything, including a grant decided this cycle.
    if (!power_on) begin
      state_d  = S_OFF;
      cmd_d    = CMD_OFF;
      cnt_d    = '0;
      err_d    = 1'b0;
      ok_d     = 1'b0;
      gnt_a_d  = 1'b0;
      gnt_b_d  = 1'b0;
      last_b_d = last_b_q;
      opcode_d = opcode_q;
      addr_d   = addr_q;
      data_d   = data_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      cmd_q    <= CMD_OFF;
      opcode_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      err_q    <= 1'b0;
      last_b_q <= 1'b1;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      err_q    <= err_d;
      last_b_q <= last_b_d;
      ok_q     <= ok_d;
    end
  end

  assign command     = cmd_q;
  assign opcode      = opcode_q;
  assign addr        = addr_q;
  assign data_addr   = data_q;
  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != S_READY);

endmodule
